// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared encodings for the pipeline stall/flush sequencer
package hazard_stall_ctrl_pkg;

    localparam int         CNT_W    = 16;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// rtl/hazard_stall_ctrl_md_busy_timer.sv - load/decrement busy timer for multi-cycle units
module md_busy_timer #(
    parameter int LATENCY = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_hold,
    output logic o_busy
);

    localparam int           W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [W-1:0] LOAD = W'(LATENCY - 1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_next;
    logic         r_busy;

    // A held start is re-presented by the stalled stage, so only accept it when not held.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_start && !i_hold) begin
            w_cnt_next = LOAD;
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_busy <= (w_cnt_next != '0);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - priority stall/flush sequencer for the 5-stage pipeline
module hazard_stall_ctrl #(
    parameter int MEM_LATENCY = 3,
    parameter int MD_LATENCY  = 8,
    parameter int CNT_W       = hazard_stall_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_reads_hilo,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_access,
    input  logic             md_start,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             md_busy,
    output logic [1:0]       mem_state,
    output logic [CNT_W-1:0] stall_cnt
);

    import hazard_stall_ctrl_pkg::*;

    localparam int              WC_W        = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam logic [WC_W-1:0] WAIT_CYCLES = WC_W'((MEM_LATENCY > 2) ? MEM_LATENCY - 2 : 0);
    localparam bit              MEM_MULTI   = (MEM_LATENCY > 1);

    mem_state_e       r_state;
    logic [WC_W-1:0]  r_wcnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_freeze;
    logic w_load_use;
    logic w_hilo;
    logic w_stall;
    logic w_flush;
    logic w_md_busy;

    assign w_freeze   = (r_state == MEM_WAIT) || ((r_state == RUN) && mem_access && MEM_MULTI);
    assign w_load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign w_hilo     = id_reads_hilo && w_md_busy;
    assign w_stall    = w_load_use || w_hilo;
    assign w_flush    = branch_taken || jump;

    // r_wcnt holds the MEM_WAIT cycles still to go, so the RUN cycle plus the
    // wait cycles together hold the pipe for MEM_LATENCY-1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_access && MEM_MULTI) begin
                        if (WAIT_CYCLES == '0) begin
                            r_state <= MEM_DONE;
                        end else begin
                            r_state <= MEM_WAIT;
                            r_wcnt  <= WAIT_CYCLES;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (r_wcnt <= WC_W'(1)) begin
                        r_state <= MEM_DONE;
                        r_wcnt  <= '0;
                    end else begin
                        r_wcnt <= r_wcnt - WC_W'(1);
                    end
                end
                MEM_DONE: r_state <= RUN;
                default:  r_state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (w_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (w_flush) begin
            if_id_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    md_busy_timer #(
        .LATENCY (MD_LATENCY)
    ) u_md_timer (
        .clk     (clk),
        .rst     (rst),
        .i_start (md_start),
        .i_hold  (w_freeze),
        .o_busy  (w_md_busy)
    );

    assign md_busy   = w_md_busy;
    assign mem_state = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int ML  = 3;
    localparam int MDL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_reads_hilo, ex_mem_read, mem_access, md_start, branch_taken, jump;

    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, md_busy;
    logic [1:0]  mem_state;
    logic [15:0] stall_cnt;

    logic        pc_write_s, if_id_write_s, if_id_flush_s, id_ex_write_s, id_ex_bubble_s, ex_mem_write_s, md_busy_s;
    logic [1:0]  mem_state_s;
    logic [3:0]  stall_cnt_s;

    logic [5:0] ctl;
    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write};

    localparam logic [5:0] CTL_RESET  = 6'b001010;
    localparam logic [5:0] CTL_FREEZE = 6'b000000;
    localparam logic [5:0] CTL_STALL  = 6'b000111;
    localparam logic [5:0] CTL_FLUSH  = 6'b111101;
    localparam logic [5:0] CTL_NORMAL = 6'b110101;

    hazard_stall_ctrl #(.MEM_LATENCY(ML), .MD_LATENCY(MDL), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_reads_hilo(id_reads_hilo), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_access(mem_access), .md_start(md_start), .branch_taken(branch_taken), .jump(jump),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
        .md_busy(md_busy), .mem_state(mem_state), .stall_cnt(stall_cnt)
    );

    hazard_stall_ctrl #(.MEM_LATENCY(ML), .MD_LATENCY(MDL), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_reads_hilo(id_reads_hilo), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_access(mem_access), .md_start(md_start), .branch_taken(branch_taken), .jump(jump),
        .pc_write(pc_write_s), .if_id_write(if_id_write_s), .if_id_flush(if_id_flush_s),
        .id_ex_write(id_ex_write_s), .id_ex_bubble(id_ex_bubble_s), .ex_mem_write(ex_mem_write_s),
        .md_busy(md_busy_s), .mem_state(mem_state_s), .stall_cnt(stall_cnt_s)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: remaining frozen cycles of the current access, a one-cycle
    // "access just finished" flag, remaining mult/div cycles and saturating stall counts.
    int m_left  = 0;
    bit m_done  = 1'b0;
    int md_left = 0;
    int m_scnt  = 0;
    int m_scnt4 = 0;

    function automatic bit f_freeze();
        return (m_left > 0) || (!m_done && mem_access && (ML > 1));
    endfunction

    function automatic bit f_stall();
        bit lu;
        lu = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        return lu || (id_reads_hilo && (md_left > 0));
    endfunction

    function automatic logic [5:0] f_ctl();
        if (f_freeze()) return CTL_FREEZE;
        if (f_stall()) return CTL_STALL;
        if (branch_taken || jump) return CTL_FLUSH;
        return CTL_NORMAL;
    endfunction

    function automatic int f_state();
        if (m_left > 0) return 1;
        if (m_done) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        bit fr;
        bit st;
        if (rst) begin
            m_left = 0; m_done = 1'b0; md_left = 0; m_scnt = 0; m_scnt4 = 0;
        end else begin
            fr = f_freeze();
            st = f_stall();
            if (fr || st) begin
                if (m_scnt < 65535) m_scnt++;
                if (m_scnt4 < 15) m_scnt4++;
            end
            if (md_start && !fr) md_left = MDL - 1;
            else if (md_left > 0) md_left--;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (mem_access && (ML > 1)) begin
                m_left = ML - 2;
                m_done = (m_left == 0);
            end
        end
    end

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; id_reads_hilo = 0;
        ex_mem_read = 0; mem_access = 0; md_start = 0; branch_taken = 0; jump = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_access = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== CTL_RESET) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RESET); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_access = 1'b0;
        @(negedge clk);
        total++;
        if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        total++;
        if (mem_state !== 2'd0) begin bad++; $display("FAIL reset_mem_state got=%0d exp=0", mem_state); end
        total++;
        if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_md_busy got=%b exp=0", md_busy); end
        total++;
        if (ctl !== CTL_NORMAL) begin bad++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, CTL_NORMAL); end
        next_cycle();
    endtask

    task automatic test_load_use();
        // {ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt, expect_stall}
        logic [17:0] tbl [6] = '{
            {1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1},
            {1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0},
            {1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0},
            {1'b1, 5'd8, 5'd1, 5'd8, 1'b0, 1'b0},
            {1'b1, 5'd8, 5'd1, 5'd8, 1'b1, 1'b1},
            {1'b1, 5'd7, 5'd6, 5'd5, 1'b1, 1'b0}
        };
        logic [5:0] exp;
        for (int i = 0; i < 6; i++) begin
            {ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt} = tbl[i][17:1];
            exp = tbl[i][0] ? CTL_STALL : CTL_NORMAL;
            @(negedge clk);
            total++;
            if (ctl !== exp) begin bad++; $display("FAIL load_use[%0d] got=%b exp=%b", i, ctl, exp); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        int exp_st [6] = '{0, 1, 2, 0, 1, 2};
        bit exp_pc [6] = '{0, 0, 1, 0, 0, 1};
        do_reset();
        mem_access = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) mem_access = 1'b0;
            @(negedge clk);
            total++;
            if (mem_state !== 2'(exp_st[c])) begin bad++; $display("FAIL mem_state[%0d] got=%0d exp=%0d", c, mem_state, exp_st[c]); end
            total++;
            if (pc_write !== exp_pc[c]) begin bad++; $display("FAIL mem_pc_write[%0d] got=%b exp=%b", c, pc_write, exp_pc[c]); end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (stall_cnt !== 16'd4) begin bad++; $display("FAIL mem_stall_cnt got=%0d exp=4", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_hilo();
        do_reset();
        md_start = 1'b1;
        @(negedge clk);
        total++;
        if (md_busy !== 1'b0) begin bad++; $display("FAIL hilo_busy0 got=%b exp=0", md_busy); end
        next_cycle();
        md_start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 2) id_reads_hilo = 1'b1;
            @(negedge clk);
            total++;
            if (md_busy !== (c < 8)) begin bad++; $display("FAIL hilo_busy[%0d] got=%b exp=%b", c, md_busy, (c < 8)); end
            total++;
            if (pc_write !== !(c >= 2 && c < 8)) begin bad++; $display("FAIL hilo_pc_write[%0d] got=%b exp=%b", c, pc_write, !(c >= 2 && c < 8)); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; branch_taken = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== CTL_STALL) begin bad++; $display("FAIL prio_stall_over_flush got=%b exp=%b", ctl, CTL_STALL); end
        next_cycle();
        ex_mem_read = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== CTL_FLUSH) begin bad++; $display("FAIL prio_flush_next got=%b exp=%b", ctl, CTL_FLUSH); end
        next_cycle();
        branch_taken = 1'b0; mem_access = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== CTL_FREEZE) begin bad++; $display("FAIL prio_freeze_run got=%b exp=%b", ctl, CTL_FREEZE); end
        next_cycle();
        mem_access = 1'b0; branch_taken = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== CTL_FREEZE || mem_state !== 2'd1) begin bad++; $display("FAIL prio_branch_in_wait got=%b/%0d exp=%b/1", ctl, mem_state, CTL_FREEZE); end
        next_cycle();
        @(negedge clk);
        total++;
        if (ctl !== CTL_FLUSH || mem_state !== 2'd2) begin bad++; $display("FAIL prio_branch_in_done got=%b/%0d exp=%b/2", ctl, mem_state, CTL_FLUSH); end
        next_cycle();
        branch_taken = 1'b0; jump = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== CTL_FLUSH) begin bad++; $display("FAIL prio_jump got=%b exp=%b", ctl, CTL_FLUSH); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        repeat (20) next_cycle();
        clear_inputs();
        @(negedge clk);
        total++;
        if (stall_cnt_s !== 4'd15) begin bad++; $display("FAIL sat_cnt4 got=%0d exp=15", stall_cnt_s); end
        total++;
        if (stall_cnt !== 16'd20) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=20", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [5:0] exp_ctl;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            ex_rt         = 5'($urandom_range(0, 3));
            id_uses_rt    = 1'($urandom_range(0, 1));
            ex_mem_read   = 1'($urandom_range(0, 1));
            id_reads_hilo = ($urandom_range(0, 2) == 0);
            mem_access    = ($urandom_range(0, 3) == 0);
            md_start      = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            exp_ctl = f_ctl();
            total++;
            if (ctl !== exp_ctl) begin bad++; $display("FAIL rnd_ctl[%0d] got=%b exp=%b", i, ctl, exp_ctl); end
            total++;
            if (md_busy !== (md_left > 0)) begin bad++; $display("FAIL rnd_md_busy[%0d] got=%b exp=%b", i, md_busy, (md_left > 0)); end
            total++;
            if (mem_state !== 2'(f_state())) begin bad++; $display("FAIL rnd_mem_state[%0d] got=%0d exp=%0d", i, mem_state, f_state()); end
            total++;
            if (stall_cnt !== 16'(m_scnt)) begin bad++; $display("FAIL rnd_stall_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, m_scnt); end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_hilo();
        test_priority();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
